// File: rtl/ct_f_spsram_rdwr_ctrl.sv
// Single-port SRAM read/write controller with a 2-entry registered response FIFO.
// Optional power-up array zeroing is built when SPSRAM_CTRL_INIT_EN is defined.
module ct_f_spsram_rdwr_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int FIFO_DEPTH = 2;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state_reg;
    logic                  rd_pend_reg;
    logic [1:0]            fifo_cnt_reg;
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [DATA_WIDTH-1:0] fifo_mem_reg [FIFO_DEPTH];

    logic       req_acc;
    logic       rd_acc;
    logic       push;
    logic       pop;
    logic [1:0] occ;
    logic       rd_room;

`ifdef SPSRAM_CTRL_INIT_EN
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt_reg;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT)
                init_cnt_reg <= init_cnt_reg + ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        if ((state_reg == ST_INIT) && (init_cnt_reg == '1))
            state_next = ST_RUN;
    end
`else
    assign state_reg = ST_RUN;
`endif

    // Occupancy counts the read in flight so the FIFO can never be overrun.
    assign occ     = fifo_cnt_reg + {1'b0, rd_pend_reg};
    assign pop     = (fifo_cnt_reg != 2'd0) & rsp_rdy;
    assign rd_room = (occ < 2'd2) | ((occ == 2'd2) & pop);
    assign push    = rd_pend_reg;
    assign req_acc = req_vld & req_rdy;
    assign rd_acc  = req_acc & ~req_wr;

    always_comb begin
        req_rdy   = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = req_addr;
        sram_d    = req_wdata;
        if (state_reg == ST_RUN) begin
            req_rdy = cpurst_b & (req_wr | rd_room);
            if (req_vld & req_rdy) begin
                sram_cen  = 1'b0;
                sram_gwen = ~req_wr;
                sram_wen  = ~req_wmask;
            end
        end
`ifdef SPSRAM_CTRL_INIT_EN
        else begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_d    = '0;
            sram_a    = init_cnt_reg;
        end
`endif
    end

    assign init_done = (state_reg == ST_RUN);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_pend_reg  <= 1'b0;
            fifo_cnt_reg <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            rd_pend_reg  <= rd_acc;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
            if (push)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b)
                fifo_mem_reg[gi] <= '0;
            else if (push && (wr_ptr_reg == 1'(gi)))
                fifo_mem_reg[gi] <= sram_q;
        end
    end

    assign rsp_vld   = (fifo_cnt_reg != 2'd0);
    assign rsp_rdata = fifo_mem_reg[rd_ptr_reg];

endmodule

// File: tb/tb_ct_f_spsram_rdwr_ctrl.sv
// Scoreboard bench for ct_f_spsram_rdwr_ctrl with a behavioural SRAM model.
`timescale 1ns/1ps
module tb_ct_f_spsram_rdwr_ctrl;

`ifdef SPSRAM_CTRL_INIT_EN
    localparam int AW      = 4;
    localparam bit INIT_EN = 1'b1;
`else
    localparam int AW      = 15;
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          cpurst_b = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    always #5 clk = ~clk;

    ct_f_spsram_rdwr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (cpurst_b),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_rdata     (rsp_rdata),
        .init_done     (init_done),
        .sram_a        (sram_a),
        .sram_cen      (sram_cen),
        .sram_gwen     (sram_gwen),
        .sram_wen      (sram_wen),
        .sram_d        (sram_d),
        .sram_q        (sram_q)
    );

    // Unwritten words hold garbage when init zeroing is expected, else a known pattern.
    function automatic logic [DW-1:0] bg_val(int a);
        if (INIT_EN)
            return '1;
        return {4{32'(a) ^ 32'h5A5A_0000}};
    endfunction

    logic [DW-1:0] sram_mem [int];
    int            sm_a;
    logic [DW-1:0] sm_cur;
    always @(posedge clk) begin
        if (!sram_cen) begin
            sm_a   = int'(sram_a);
            sm_cur = sram_mem.exists(sm_a) ? sram_mem[sm_a] : bg_val(sm_a);
            if (!sram_gwen)
                sram_mem[sm_a] = (sm_cur & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sm_cur;
        end
    end

    logic [DW-1:0] ref_mem [int];
    function automatic logic [DW-1:0] ref_rd(int a);
        if (ref_mem.exists(a))
            return ref_mem[a];
        return INIT_EN ? '0 : bg_val(a);
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        int            addr;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int last_rsp_cyc = -100;
    bit last_acc = 1'b0;

    // Called at posedge+1 (or later in the cycle); samples at negedge and returns at next posedge+1.
    task automatic clock_cycle();
        exp_t e;
        int   a;
        @(negedge clk);
        last_acc = req_vld && req_rdy;
        if (last_acc) begin
            a = int'(req_addr);
            if (req_wr) begin
                ref_mem[a] = (ref_rd(a) & ~req_wmask) | (req_wdata & req_wmask);
                $display("wr  addr=%h data=%h mask=%h", req_addr, req_wdata, req_wmask);
            end else begin
                e.data = ref_rd(a);
                e.cyc  = cyc;
                e.addr = a;
                exp_q.push_back(e);
            end
        end
        if (rsp_vld && rsp_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rsp_unexpected: got data=%h, required no response", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if (rsp_rdata !== e.data)
                    $display("FAIL rsp_data addr=%h: got %h, required %h", e.addr, rsp_rdata, e.data);
                else begin
                    passed++;
                    $display("rd  addr=%h data=%h lat=%0d", e.addr, rsp_rdata, cyc - e.cyc);
                end
            end
            rsp_cnt++;
            last_rsp_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(bit wr, int a, logic [DW-1:0] d, logic [DW-1:0] m);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = AW'(a);
        req_wdata = d;
        req_wmask = m;
        for (int t = 0; t < 20; t++) begin
            clock_cycle();
            if (last_acc)
                break;
        end
        req_vld = 1'b0;
        checks++;
        if (!last_acc)
            $display("FAIL issue_accept addr=%h wr=%0d: got not accepted, required accepted", a, wr);
        else
            passed++;
    endtask

    task automatic drain();
        for (int t = 0; t < 30 && exp_q.size() != 0; t++)
            clock_cycle();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        else
            passed++;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        rsp_rdy  = 1'b1;
        req_vld  = 1'b1;
        req_wr   = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if ({req_rdy, rsp_vld, sram_cen} !== 3'b001)
            $display("FAIL reset_hs: got rdy/vld/cen=%b, required 001", {req_rdy, rsp_vld, sram_cen});
        else
            passed++;
        checks++;
        if (init_done !== !INIT_EN)
            $display("FAIL reset_init_done: got %b, required %b", init_done, !INIT_EN);
        else
            passed++;
        req_vld = 1'b0;
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
    endtask

    task automatic test_init();
`ifdef SPSRAM_CTRL_INIT_EN
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            #3;
            if ({sram_cen, sram_gwen, req_rdy, init_done} !== 4'b0000 || sram_wen !== '0 ||
                sram_d !== '0 || sram_a !== AW'(i)) begin
                bad++;
                $display("FAIL init_cycle %0d: got cen/gwen/rdy/done=%b a=%h, required 0000 a=%h",
                         i, {sram_cen, sram_gwen, req_rdy, init_done}, sram_a, i);
            end
            clock_cycle();
        end
        checks++;
        if (bad == 0)
            passed++;
        #3;
        checks++;
        if ({init_done, req_rdy} !== 2'b11)
            $display("FAIL init_exit: got done/rdy=%b, required 11", {init_done, req_rdy});
        else
            passed++;
`else
        #3;
        checks++;
        if ({init_done, req_rdy} !== 2'b11)
            $display("FAIL run_after_reset: got done/rdy=%b, required 11", {init_done, req_rdy});
        else
            passed++;
`endif
        issue(1'b0, 5, '0, '0);
        drain();
    endtask

    task automatic test_write_read();
        int            a = int'(AW'('h1234));
        int            acc_c;
        int            n0;
        logic [DW-1:0] d = {16{8'hA5}};
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = AW'(a);
        req_wdata = d;
        req_wmask = '1;
        #3;
        checks++;
        if ({req_rdy, sram_cen, sram_gwen} !== 3'b100 || sram_a !== AW'(a) || sram_d !== d || sram_wen !== '0)
            $display("FAIL wr_pins: got rdy/cen/gwen=%b a=%h wen=%h, required 100 a=%h wen=0",
                     {req_rdy, sram_cen, sram_gwen}, sram_a, sram_wen, a);
        else
            passed++;
        clock_cycle();
        req_wr = 1'b0;
        #3;
        checks++;
        if ({req_rdy, sram_cen, sram_gwen} !== 3'b101)
            $display("FAIL rd_pins: got rdy/cen/gwen=%b, required 101", {req_rdy, sram_cen, sram_gwen});
        else
            passed++;
        acc_c = cyc;
        n0    = rsp_cnt;
        clock_cycle();
        req_vld = 1'b0;
        for (int t = 0; t < 10 && rsp_cnt == n0; t++)
            clock_cycle();
        checks++;
        if (rsp_cnt == n0 || last_rsp_cyc - acc_c != 2)
            $display("FAIL rd_latency: got %0d cycles (rsp_cnt delta %0d), required 2",
                     last_rsp_cyc - acc_c, rsp_cnt - n0);
        else
            passed++;
        drain();
        #3;
        checks++;
        if ({sram_cen, sram_gwen} !== 2'b11 || sram_wen !== '1)
            $display("FAIL idle_pins: got cen/gwen=%b wen=%h, required 11 all-ones", {sram_cen, sram_gwen}, sram_wen);
        else
            passed++;
    endtask

    task automatic test_masked_write();
        int a = 9;
        issue(1'b1, a, '1, '1);
        issue(1'b1, a, '0, DW'('h00FF));
        issue(1'b0, a, '0, '0);
        drain();
    endtask

    task automatic test_backpressure();
        int addrs[5];
        int idx = 0;
        int stall = 0;
        for (int i = 0; i < 5; i++)
            addrs[i] = int'($urandom_range(0, (1 << AW) - 1));
        rsp_rdy = 1'b0;
        req_vld = 1'b1;
        req_wr  = 1'b0;
        for (int t = 0; t < 6; t++) begin
            req_addr = AW'(addrs[idx < 4 ? idx : 4]);
            clock_cycle();
            if (last_acc)
                idx++;
        end
        #3;
        checks++;
        if (idx != 2 || req_rdy !== 1'b0)
            $display("FAIL bp_stall: got accepted=%0d rdy=%b, required 2 and 0", idx, req_rdy);
        else
            passed++;
        rsp_rdy = 1'b1;
        for (int t = 0; t < 10 && idx < 4; t++) begin
            req_addr = AW'(addrs[idx]);
            clock_cycle();
            if (last_acc)
                idx++;
            else
                stall++;
        end
        req_vld = 1'b0;
        checks++;
        if (idx != 4 || stall != 0)
            $display("FAIL bp_resume: got accepted=%0d stalls=%0d, required 4 and 0", idx, stall);
        else
            passed++;
        drain();
    endtask

    task automatic test_stream();
        int n = 0;
        int stall = 0;
        int start_c = -1;
        int n0 = rsp_cnt;
        rsp_rdy = 1'b1;
        req_vld = 1'b1;
        req_wr  = 1'b0;
        for (int t = 0; t < 200 && n < 100; t++) begin
            req_addr = AW'($urandom_range(0, (1 << AW) - 1));
            if (start_c < 0)
                start_c = cyc;
            clock_cycle();
            if (last_acc)
                n++;
            else
                stall++;
        end
        req_vld = 1'b0;
        drain();
        checks++;
        if (stall != 0 || n != 100)
            $display("FAIL stream_rdy: got accepted=%0d stalls=%0d, required 100 and 0", n, stall);
        else
            passed++;
        checks++;
        if (rsp_cnt - n0 != 100 || last_rsp_cyc != start_c + 101)
            $display("FAIL stream_rsp: got %0d responses last at +%0d, required 100 last at +101",
                     rsp_cnt - n0, last_rsp_cyc - start_c);
        else
            passed++;
    endtask

    task automatic test_midop_reset();
        int n0;
        rsp_rdy = 1'b0;
        issue(1'b0, 3, '0, '0);
        issue(1'b0, 7, '0, '0);
        clock_cycle();
        clock_cycle();
        #3;
        checks++;
        if (rsp_vld !== 1'b1)
            $display("FAIL midrst_pending: got rsp_vld=%b, required 1", rsp_vld);
        else
            passed++;
        cpurst_b = 1'b0;
        #1;
        checks++;
        if ({rsp_vld, req_rdy} !== 2'b00)
            $display("FAIL midrst_async: got vld/rdy=%b, required 00", {rsp_vld, req_rdy});
        else
            passed++;
        exp_q.delete();
        if (INIT_EN)
            ref_mem.delete();
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        rsp_rdy  = 1'b1;
        n0 = rsp_cnt;
        repeat (20) clock_cycle();
        checks++;
        if (rsp_cnt != n0)
            $display("FAIL midrst_stale: got %0d responses, required 0", rsp_cnt - n0);
        else
            passed++;
        issue(1'b0, 3, '0, '0);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_masked_write();
        test_backpressure();
        test_stream();
        test_midop_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
